// File: rtl/display_scanner_pkg.sv
// Shared constants for the 8-digit multiplexed display scanner: digit code
// fields, glyph codes and the glyph-to-segment table ({g,f,e,d,c,b,a}, active-low).
package display_scanner_pkg;

    localparam logic [5:0] BLANK_CODE = 6'b100000;

    localparam logic [3:0] GLYPH_0    = 4'h0;  // also "O"
    localparam logic [3:0] GLYPH_1    = 4'h1;
    localparam logic [3:0] GLYPH_2    = 4'h2;
    localparam logic [3:0] GLYPH_3    = 4'h3;
    localparam logic [3:0] GLYPH_Y    = 4'h4;
    localparam logic [3:0] GLYPH_5    = 4'h5;  // also "S"
    localparam logic [3:0] GLYPH_G    = 4'h6;
    localparam logic [3:0] GLYPH_T    = 4'h7;
    localparam logic [3:0] GLYPH_8    = 4'h8;  // also "B"
    localparam logic [3:0] GLYPH_L    = 4'h9;
    localparam logic [3:0] GLYPH_A    = 4'hA;
    localparam logic [3:0] GLYPH_J    = 4'hB;
    localparam logic [3:0] GLYPH_U    = 4'hC;
    localparam logic [3:0] GLYPH_P    = 4'hD;
    localparam logic [3:0] GLYPH_E    = 4'hE;
    localparam logic [3:0] GLYPH_DASH = 4'hF;

    // Entry N is the segment pattern for glyph code N.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111111,  // F "-"
        7'b0000110,  // E "E"
        7'b0001100,  // D "P"
        7'b1000001,  // C "U"
        7'b1100001,  // B "J"
        7'b0001000,  // A "A"
        7'b1000111,  // 9 "L"
        7'b0000000,  // 8
        7'b0000111,  // 7 "T"
        7'b1000010,  // 6 "G"
        7'b0010010,  // 5
        7'b0010001,  // 4 "Y"
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] glyph_segments(input logic [3:0] code);
        return SEG_TABLE[code];
    endfunction

endpackage

// File: rtl/display_scanner_seg7_decoder.sv
// Combinational glyph decoder: 4-bit glyph code to active-low {g,f,e,d,c,b,a}.
module seg7_decoder
    import display_scanner_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    assign seg = glyph_segments(code);

endmodule

// File: rtl/display_scanner.sv
// Eight-digit multiplexed display scanner: prescaled slot scan, frame-latched
// digit codes so a frame never mixes old and new data, registered outputs.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic             tick;
    logic [5:0]       frame [8];
    logic [5:0]       sel;
    logic [6:0]       glyph;

    // With REFRESH_DIV=1 the counter is stuck at 0 == CNT_LAST, so tick fires every cycle.
    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                frame[i] <= BLANK_CODE;
            end
        end else if (tick && idx == 3'd7) begin
            frame[0] <= d1;
            frame[1] <= d2;
            frame[2] <= d3;
            frame[3] <= d4;
            frame[4] <= d5;
            frame[5] <= d6;
            frame[6] <= d7;
            frame[7] <= d8;
        end
    end

    assign sel = frame[idx];

    seg7_decoder u_decoder (
        .code (sel[4:1]),
        .seg  (glyph)
    );

    // Output stage: one cycle behind idx; a blanked slot drives nothing at all.
    always_ff @(posedge clock) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (sel[5]) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'h80 >> idx);
            seg <= glyph;
            dp  <= ~sel[0];
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: glyph vector table, hand-written scan/tearing/reset
// sequences, and randomized digit traffic checked against a frame-level model.
module tb_display_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  [2];
    logic [5:0] din  [2][8];
    logic [7:0] an   [2];
    logic [6:0] seg  [2];
    logic       dp   [2];

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [3:0] code;
        logic [6:0] seg;
    } vec_t;
    vec_t vtab [16];

    display_scanner #(.REFRESH_DIV(4)) dut0 (
        .clock(clk), .reset(rst[0]),
        .d1(din[0][0]), .d2(din[0][1]), .d3(din[0][2]), .d4(din[0][3]),
        .d5(din[0][4]), .d6(din[0][5]), .d7(din[0][6]), .d8(din[0][7]),
        .an(an[0]), .seg(seg[0]), .dp(dp[0])
    );

    display_scanner #(.REFRESH_DIV(1)) dut1 (
        .clock(clk), .reset(rst[1]),
        .d1(din[1][0]), .d2(din[1][1]), .d3(din[1][2]), .d4(din[1][3]),
        .d5(din[1][4]), .d6(din[1][5]), .d7(din[1][6]), .d8(din[1][7]),
        .an(an[1]), .seg(seg[1]), .dp(dp[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Reference model: position within the frame is just the number of cycles
    // since reset modulo 8*DIV; slot = position / DIV.
    int         mj     [2];
    logic [5:0] mframe [2][8];
    logic [7:0] ean    [2];
    logic [6:0] eseg   [2];
    logic       edp    [2];
    bit         mvalid [2] = '{1'b0, 1'b0};

    function automatic logic [7:0] model_an(input logic [5:0] c, input int slot);
        return c[5] ? 8'hFF : ~(8'h01 << (7 - slot));
    endfunction

    function automatic logic [6:0] model_seg(input logic [5:0] c);
        return c[5] ? 7'h7F : vtab[c[4:1]].seg;
    endfunction

    function automatic logic model_dp(input logic [5:0] c);
        return !(c[0] && !c[5]);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                mj[i]     <= 0;
                ean[i]    <= 8'hFF;
                eseg[i]   <= 7'h7F;
                edp[i]    <= 1'b1;
                mvalid[i] <= 1'b1;
                for (int s = 0; s < 8; s++) mframe[i][s] <= 6'b100000;
            end else begin
                ean[i]  <= model_an(mframe[i][(mj[i] / div_of(i)) % 8], (mj[i] / div_of(i)) % 8);
                eseg[i] <= model_seg(mframe[i][(mj[i] / div_of(i)) % 8]);
                edp[i]  <= model_dp(mframe[i][(mj[i] / div_of(i)) % 8]);
                mj[i]   <= (mj[i] + 1) % (8 * div_of(i));
                if ((mj[i] + 1) % (8 * div_of(i)) == 0)
                    for (int s = 0; s < 8; s++) mframe[i][s] <= din[i][s];
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mvalid[i]) begin
                check(i == 0 ? "model_an_div4"  : "model_an_div1",  {24'd0, an[i]},  {24'd0, ean[i]});
                check(i == 0 ? "model_seg_div4" : "model_seg_div1", {25'd0, seg[i]}, {25'd0, eseg[i]});
                check(i == 0 ? "model_dp_div4"  : "model_dp_div1",  {31'd0, dp[i]},  {31'd0, edp[i]});
                check("an_at_most_one_low", {31'd0, ($countones(~an[i]) <= 1)}, 32'd1);
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        logic [5:0] rc;

        vtab[0]  = '{4'h0, 7'b1000000};
        vtab[1]  = '{4'h1, 7'b1111001};
        vtab[2]  = '{4'h2, 7'b0100100};
        vtab[3]  = '{4'h3, 7'b0110000};
        vtab[4]  = '{4'h4, 7'b0010001};
        vtab[5]  = '{4'h5, 7'b0010010};
        vtab[6]  = '{4'h6, 7'b1000010};
        vtab[7]  = '{4'h7, 7'b0000111};
        vtab[8]  = '{4'h8, 7'b0000000};
        vtab[9]  = '{4'h9, 7'b1000111};
        vtab[10] = '{4'hA, 7'b0001000};
        vtab[11] = '{4'hB, 7'b1100001};
        vtab[12] = '{4'hC, 7'b1000001};
        vtab[13] = '{4'hD, 7'b0001100};
        vtab[14] = '{4'hE, 7'b0000110};
        vtab[15] = '{4'hF, 7'b0111111};

        rst[0] = 1'b1;
        rst[1] = 1'b1;
        for (int s = 0; s < 8; s++) begin
            din[0][s] = {1'b0, 4'(s), 1'b0};
            din[1][s] = {1'b0, 4'($urandom_range(15)), 1'b0};
        end

        // Reset held three cycles, then blank until the first frame boundary.
        wait_neg(3);
        check("reset_an",  {24'd0, an[0]},  32'hFF);
        check("reset_seg", {25'd0, seg[0]}, 32'h7F);
        check("reset_dp",  {31'd0, dp[0]},  32'd1);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (an[0] == 8'hFF && k < 100);
        check("first_frame_latency", k, 33);

        // Scan order: each anode held 4 cycles, left to right, then wrap.
        check("slot0_seg", {25'd0, seg[0]}, {25'd0, 7'b1000000});
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 4; c++) begin
                check("scan_an", {24'd0, an[0]}, {24'd0, 8'hFF & ~(8'h80 >> s)});
                @(negedge clk);
            end
        end
        check("scan_wrap", {24'd0, an[0]}, 32'h7F);

        // Tearing: d3 changes mid-frame; only frame boundaries pick it up.
        wait_neg(20);
        din[0][2] = {1'b0, 4'hE, 1'b0};
        wait_neg(16);
        din[0][2] = {1'b0, 4'h2, 1'b0};
        wait_neg(4);
        check("tear_next_an",  {24'd0, an[0]},  32'hDF);
        check("tear_next_seg", {25'd0, seg[0]}, {25'd0, 7'b0000110});
        wait_neg(32);
        check("tear_back_seg", {25'd0, seg[0]}, {25'd0, 7'b0100100});

        // Blanked digit with DP requested stays dark; next digit shows J with DP.
        din[0][3] = 6'b100001;
        din[0][4] = {1'b0, 4'hB, 1'b1};
        wait_neg(36);
        check("blank_an", {24'd0, an[0]}, 32'hFF);
        check("blank_dp", {31'd0, dp[0]}, 32'd1);
        wait_neg(4);
        check("j_an",  {24'd0, an[0]},  32'hF7);
        check("j_seg", {25'd0, seg[0]}, {25'd0, 7'b1100001});
        check("j_dp",  {31'd0, dp[0]},  32'd0);

        // Glyph table: every digit shows the same code, so any slot works.
        for (int v = 0; v < 16; v++) begin
            for (int s = 0; s < 8; s++) din[0][s] = {1'b0, vtab[v].code, 1'b0};
            wait_neg(64);
            check("glyph_seg", {25'd0, seg[0]}, {25'd0, vtab[v].seg});
            check("glyph_dp",  {31'd0, dp[0]},  32'd1);
        end

        // REFRESH_DIV=1: slot advances every cycle; reset at index 5 restarts the scan.
        for (int s = 0; s < 8; s++) din[1][s] = {1'b0, 4'(s + 1), 1'b0};
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        wait_neg(9);
        for (int s = 0; s < 5; s++) begin
            check("div1_step_an", {24'd0, an[1]}, {24'd0, 8'hFF & ~(8'h80 >> s)});
            @(negedge clk);
        end
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        check("div1_reset_an",  {24'd0, an[1]},  32'hFF);
        check("div1_reset_seg", {25'd0, seg[1]}, 32'h7F);
        check("div1_reset_dp",  {31'd0, dp[1]},  32'd1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (an[1] == 8'hFF && k < 50);
        check("div1_restart_latency", k, 9);
        check("div1_restart_slot0", {24'd0, an[1]}, 32'h7F);

        // Random digit traffic with occasional resets, checked by the model.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                rst[i] = ($urandom_range(299) == 0);
                if ($urandom_range(7) == 0) begin
                    rc = 6'($urandom);
                    if ($urandom_range(3) != 0) rc[5] = 1'b0;
                    din[i][$urandom_range(7)] = rc;
                end
            end
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        wait_neg(4);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
